// File: rtl/cdce62005_spi_responder_pkg.sv
// Shared definitions for the CDCE62005 SPI responder: command codes,
// register-file defaults and the frame FSM state type.
package cdce62005_pkg;

    localparam logic [3:0] CMD_RD     = 4'hE;
    localparam logic [3:0] CMD_EE     = 4'hF;
    localparam int         NUM_REGS   = 9;
    localparam int         FRAME_BITS = 32;
    localparam int         DATA_W     = 28;

    // Power-up contents of registers 0..7 (data field, bits [31:4] of the word)
    localparam logic [DATA_W-1:0] REG_DEFAULT [0:7] = '{
        28'h8140030, 28'h8140030, 28'h8140030, 28'hE840030,
        28'hE840030, 28'h10008F3, 28'h04BE03E, 28'h0000000
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    // Commands 0..8 address the register file directly
    function automatic logic is_write_cmd(input logic [3:0] cmd);
        return cmd <= 4'd8;
    endfunction

endpackage

// File: rtl/cdce62005_spi_responder_if.sv
// Four-wire SPI link between the configuration master and the responder.
interface cdce62005_spi_responder_if;

    logic spi_clk;
    logic spi_le;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_clk,
        output spi_le,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_clk,
        input  spi_le,
        input  spi_mosi,
        output spi_miso
    );

endinterface

// File: rtl/cdce62005_spi_responder_spi_in_sync.sv
// Brings spi_clk, spi_le and spi_mosi into the clk domain and detects
// spi_clk rising edges and spi_le edges on the synchronized copies.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    input  logic spi_le,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic le_rise,
    output logic le_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] le_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   clk_prev;
    logic                   le_prev;

    // Synchronizer chains plus edge-history flops; spi_le resets to its idle-high
    // level so releasing rst never looks like the start of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '0;
            le_sync   <= '1;
            mosi_sync <= '0;
            clk_prev  <= 1'b0;
            le_prev   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            le_sync   <= {le_sync[SYNC_STAGES-2:0], spi_le};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            le_prev   <= le_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign le_rise   = le_sync[SYNC_STAGES-1] & ~le_prev;
    assign le_fall   = ~le_sync[SYNC_STAGES-1] & le_prev;
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdce62005_spi_responder.sv
// CDCE62005 register-interface responder: decodes 32-bit LSB-first SPI
// frames into a 9-entry register file, returns read-back data in the frame
// following a read command and models the EEPROM copy busy period.
module cdce62005_spi_responder
    import cdce62005_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          EE_BUSY_CYC = 1024,
    parameter logic [27:0] STATUS_INIT = 28'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    cdce62005_spi_responder_if.slave     spi,
    input  logic [3:0]                   status_in,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [3:0]                   wr_addr,
    output logic                         eeprom_busy,
    output logic [7:0]                   ee_copy_cnt,
    output logic                         frame_err
);

    localparam int BUSY_W = (EE_BUSY_CYC > 2) ? $clog2(EE_BUSY_CYC) : 1;

    logic              sclk_rise;
    logic              le_rise;
    logic              le_fall;
    logic              mosi_s;

    state_t            state;
    logic [5:0]        bit_cnt;
    logic [31:0]       sr;
    logic [31:0]       tx_sr;
    logic              miso_q;
    logic              rd_pend;
    logic [3:0]        rd_addr;
    logic [BUSY_W-1:0] busy_cnt;

    logic [DATA_W-1:0] regs_q [0:7];
    logic [23:0]       reg8_hi;
    logic [3:0]        status_q;
    logic [DATA_W-1:0] reg_view [0:NUM_REGS-1];
    logic [DATA_W-1:0] rd_data;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi.spi_clk),
        .spi_le    (spi.spi_le),
        .spi_mosi  (spi.spi_mosi),
        .sclk_rise (sclk_rise),
        .le_rise   (le_rise),
        .le_fall   (le_fall),
        .mosi_s    (mosi_s)
    );

    // Unified view of the register file; reg8 low nibble is the live status
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            reg_view[i] = regs_q[i];
        end
        reg_view[8] = {reg8_hi, status_q};
        rd_data     = (rd_addr <= 4'd8) ? reg_view[rd_addr] : '0;
    end

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_flat
        assign regs_flat[DATA_W*n +: DATA_W] = reg_view[n];
    end

    assign spi.spi_miso = miso_q;

    // Live status bits mirrored into reg8[7:4]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= STATUS_INIT[3:0];
        end else begin
            status_q <= status_in;
        end
    end

    // Receive shift register: LSB-first, each bit enters at the top.
    // Frame validity is carried by bit_cnt, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (state == ST_SHIFT && sclk_rise) begin
            sr <= {mosi_s, sr[31:1]};
        end
    end

    // Frame FSM, register file, read-back shifter and EEPROM busy timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            miso_q      <= 1'b0;
            rd_pend     <= 1'b0;
            rd_addr     <= '0;
            busy_cnt    <= '0;
            eeprom_busy <= 1'b0;
            ee_copy_cnt <= '0;
            frame_err   <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            reg8_hi     <= STATUS_INIT[27:4];
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= REG_DEFAULT[i];
            end
        end else begin
            wr_strobe <= 1'b0;

            if (eeprom_busy) begin
                if (busy_cnt == '0) begin
                    eeprom_busy <= 1'b0;
                end else begin
                    busy_cnt <= busy_cnt - BUSY_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (le_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        if (rd_pend) begin
                            tx_sr   <= {rd_data, rd_addr};
                            miso_q  <= rd_addr[0];
                            rd_pend <= 1'b0;
                        end else begin
                            tx_sr  <= '0;
                            miso_q <= 1'b0;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (sclk_rise) begin
                        if (bit_cnt != 6'd33) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                        tx_sr  <= {1'b0, tx_sr[31:1]};
                        miso_q <= tx_sr[1];
                    end
                    if (le_rise) begin
                        state  <= ST_EXEC;
                        tx_sr  <= '0;
                        miso_q <= 1'b0;
                    end
                end

                ST_EXEC: begin
                    state <= ST_IDLE;
                    if (bit_cnt != 6'(FRAME_BITS)) begin
                        frame_err <= 1'b1;
                    end else if (is_write_cmd(sr[3:0])) begin
                        if (eeprom_busy) begin
                            frame_err <= 1'b1;
                        end else begin
                            if (sr[3:0] == 4'd8) begin
                                reg8_hi <= sr[31:8];
                            end else begin
                                regs_q[sr[2:0]] <= sr[31:4];
                            end
                            wr_strobe <= 1'b1;
                            wr_addr   <= sr[3:0];
                        end
                    end else if (sr[3:0] == CMD_RD) begin
                        if (sr[7:4] > 4'd8) begin
                            frame_err <= 1'b1;
                        end else begin
                            rd_addr <= sr[7:4];
                            rd_pend <= 1'b1;
                        end
                    end else if (sr[3:0] == CMD_EE && sr[31:4] == 28'd1) begin
                        if (eeprom_busy) begin
                            frame_err <= 1'b1;
                        end else begin
                            eeprom_busy <= 1'b1;
                            busy_cnt    <= BUSY_W'(EE_BUSY_CYC - 1);
                            if (ee_copy_cnt != 8'hFF) begin
                                ee_copy_cnt <= ee_copy_cnt + 8'd1;
                            end
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdce62005_spi_responder.sv
// Directed plus randomized bench for the CDCE62005 SPI responder, checked
// against a frame-level reference model of the register interface.
module tb_cdce62005_spi_responder;
    import cdce62005_pkg::*;

    localparam int EE_CYC = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   status_in;
    logic [251:0] regs_flat;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic         eeprom_busy;
    logic [7:0]   ee_copy_cnt;
    logic         frame_err;

    cdce62005_spi_responder_if spi ();

    cdce62005_spi_responder #(
        .SYNC_STAGES (2),
        .EE_BUSY_CYC (EE_CYC),
        .STATUS_INIT (28'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi.slave),
        .status_in   (status_in),
        .regs_flat   (regs_flat),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .eeprom_busy (eeprom_busy),
        .ee_copy_cnt (ee_copy_cnt),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int strobe_cnt  = 0;
    int busy_cycles = 0;

    // Monitors: count strobe pulses and busy cycles, sampled on the inactive edge
    always @(negedge clk) begin
        if (wr_strobe)   strobe_cnt  <= strobe_cnt + 1;
        if (eeprom_busy) busy_cycles <= busy_cycles + 1;
    end

    // Reference model of the register interface
    logic [27:0] m_regs [0:7];
    logic [23:0] m_r8hi;
    logic        m_busy;
    int          m_copies;
    logic        m_err;
    logic        m_pend;
    logic [3:0]  m_rdaddr;
    logic [3:0]  m_wraddr;
    int          m_strobe;

    function automatic logic [27:0] m_reg(input int n);
        if (n < 8) return m_regs[n];
        return {m_r8hi, status_in};
    endfunction

    function automatic logic [251:0] m_flat();
        logic [251:0] f;
        for (int n = 0; n < 9; n++) f[28*n +: 28] = m_reg(n);
        return f;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = REG_DEFAULT[i];
        m_r8hi   = 24'h0;
        m_busy   = 1'b0;
        m_copies = 0;
        m_err    = 1'b0;
        m_pend   = 1'b0;
        m_rdaddr = 4'h0;
        m_wraddr = 4'h0;
    endtask

    task automatic model_decode(input logic [31:0] w);
        logic [3:0] cmd;
        cmd = w[3:0];
        m_strobe = 0;
        if (cmd <= 4'd8) begin
            if (m_busy) m_err = 1'b1;
            else begin
                if (cmd == 4'd8) m_r8hi = w[31:8];
                else             m_regs[cmd] = w[31:4];
                m_wraddr = cmd;
                m_strobe = 1;
            end
        end else if (cmd == 4'hE) begin
            if (w[7:4] > 4'd8) m_err = 1'b1;
            else begin
                m_pend   = 1'b1;
                m_rdaddr = w[7:4];
            end
        end else if (cmd == 4'hF && w[31:4] == 28'd1) begin
            if (m_busy) m_err = 1'b1;
            else begin
                m_busy = 1'b1;
                if (m_copies < 255) m_copies++;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        spi.spi_le   = 1'b1;
        spi.spi_clk  = 1'b0;
        spi.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
    endtask

    // Clocks nbits bits of w out on MOSI, capturing MISO before each rising edge
    task automatic shift_bits(input logic [31:0] w, input int nbits, output logic [31:0] miso_w);
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) spi.spi_mosi = w[i];
            else        spi.spi_mosi = 1'b0;
            repeat (5) @(negedge clk);
            if (i < 32) miso_w[i] = spi.spi_miso;
            spi.spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            spi.spi_clk = 1'b0;
        end
    endtask

    // One complete frame with model update and post-frame checks
    task automatic do_frame(input string tag, input logic [31:0] w, input int nbits, output logic [31:0] rb);
        logic        rb_exp_valid;
        logic [31:0] rb_exp;
        int          s0;
        rb_exp_valid = m_pend;
        rb_exp       = {m_reg(int'(m_rdaddr)), m_rdaddr};
        m_pend       = 1'b0;
        s0           = strobe_cnt;
        spi.spi_le   = 1'b0;
        repeat (6) @(negedge clk);
        shift_bits(w, nbits, rb);
        repeat (5) @(negedge clk);
        spi.spi_le = 1'b1;
        repeat (10) @(negedge clk);
        check({tag, "_miso_idle"}, spi.spi_miso, 1'b0);
        if (rb_exp_valid && nbits >= 32) check({tag, "_readback"}, rb, rb_exp);
        m_strobe = 0;
        if (nbits != 32) m_err = 1'b1;
        else             model_decode(w);
        check({tag, "_regs"}, regs_flat, m_flat());
        check({tag, "_frame_err"}, frame_err, m_err);
        check({tag, "_strobes"}, strobe_cnt - s0, m_strobe);
        check({tag, "_wr_addr"}, wr_addr, m_wraddr);
        check({tag, "_copies"}, ee_copy_cnt, m_copies);
    endtask

    initial begin
        logic [31:0] rb;
        logic [31:0] w;
        int          nb;
        int          kind;
        int          b0;
        int          guard;

        status_in = 4'h0;
        do_reset();

        // Reset state
        check("rst_regs", regs_flat, m_flat());
        check("rst_reg0_default", regs_flat[27:0], 28'h8140030);
        check("rst_miso", spi.spi_miso, 1'b0);
        check("rst_busy", eeprom_busy, 1'b0);
        check("rst_copies", ee_copy_cnt, 8'h0);
        check("rst_err", frame_err, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 4'h0);

        // 1: plain write to reg0
        do_frame("t1", 32'h81400300, 32, rb);
        check("t1_reg0", regs_flat[27:0], 28'h8140030);
        check("t1_err", frame_err, 1'b0);

        // 2: write reg1, read it back in the frame after the read command
        do_frame("t2w", 32'h81400301, 32, rb);
        do_frame("t2r", 32'h0000001E, 32, rb);
        do_frame("t2d", 32'h00000000, 32, rb);
        check("t2_word", rb, 32'h81400301);

        // 3: EEPROM copy, then a rejected write during the busy period
        b0 = busy_cycles;
        do_frame("t3c", 32'h0000001F, 32, rb);
        check("t3_busy_high", eeprom_busy, 1'b1);
        check("t3_count", ee_copy_cnt, 8'd1);
        do_frame("t3w", 32'h12345672, 32, rb);
        check("t3_reg2_kept", regs_flat[28*2 +: 28], 28'h8140030);
        check("t3_err", frame_err, 1'b1);
        guard = 0;
        while (eeprom_busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("t3_busy_fell", eeprom_busy, 1'b0);
        check("t3_busy_len", busy_cycles - b0, EE_CYC);
        m_busy = 1'b0;

        // 4: frame aborted after 20 clocks
        do_reset();
        do_frame("t4", 32'hDEADBEE3, 20, rb);
        check("t4_reg3", regs_flat[28*3 +: 28], 28'hE840030);
        check("t4_err", frame_err, 1'b1);

        // 6: reset in the middle of a write to reg5
        spi.spi_le = 1'b0;
        repeat (6) @(negedge clk);
        shift_bits(32'hCAFEF005, 16, rb);
        do_reset();
        check("t6_reg5", regs_flat[28*5 +: 28], 28'h10008F3);
        check("t6_err", frame_err, 1'b0);
        do_frame("t6w", 32'hCAFEF005, 32, rb);
        check("t6_reg5_new", regs_flat[28*5 +: 28], 28'hCAFEF00);

        // 5: read reg8 with live status, then an out-of-range read
        status_in = 4'hA;
        do_frame("t5r", 32'h0000008E, 32, rb);
        do_frame("t5d", 32'h00000000, 32, rb);
        check("t5_status_nib", rb[7:4], 4'hA);
        check("t5_addr_nib", rb[3:0], 4'h8);
        check("t5_err_before", frame_err, 1'b0);
        do_frame("t5bad", 32'h0000009E, 32, rb);
        check("t5_err_after", frame_err, 1'b1);

        // Randomized frames against the reference model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            status_in = 4'($urandom_range(0, 15));
            kind      = $urandom_range(0, 9);
            nb        = 32;
            w         = $urandom;
            if (kind <= 5) begin
                w[3:0] = 4'($urandom_range(0, 8));
            end else if (kind <= 7) begin
                w        = 32'h0;
                w[7:4]   = 4'($urandom_range(0, 10));
                w[3:0]   = 4'hE;
                w[31:8]  = 24'($urandom);
            end else if (kind == 8) begin
                w[3:0] = 4'($urandom_range(9, 15));
                if (w[3:0] == 4'hF) w[5] = 1'b1;
            end else begin
                nb = ($urandom_range(0, 3) == 0) ? 33 : $urandom_range(1, 31);
            end
            do_frame($sformatf("rnd%0d", it), w, nb, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
